// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg : ALU operation codes, alu_op encodings and branch funct3 codes    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALUOP_R   = 2'b00;
  localparam logic [1:0] ALUOP_I   = 2'b01;
  localparam logic [1:0] ALUOP_ADD = 2'b10;
  localparam logic [1:0] ALUOP_BR  = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Equality branches use the XOR zero flag; compares use the SLT/SLTU bit 0.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic res0);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = res0;
      F3_BGE:  taken = ~res0;
      F3_BLTU: taken = res0;
      F3_BGEU: taken = ~res0;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_decode : instruction + alu_op -> 4-bit ALU code and illegal flag    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [1:0]  alu_op,
  output logic [3:0]  code,
  output logic        illegal
);

  logic [2:0] funct3;
  logic       bit30;
  logic       unused_instr_bits;

  assign funct3            = instr[14:12];
  assign bit30             = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:0]};

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_R: begin
        case ({funct3, bit30})
          4'b0000: code = ALU_ADD;
          4'b0001: code = ALU_SUB;
          4'b1000: code = ALU_XOR;
          4'b1100: code = ALU_OR;
          4'b1110: code = ALU_AND;
          4'b0010: code = ALU_SLL;
          4'b1010: code = ALU_SRL;
          4'b1011: code = ALU_SRA;
          4'b0100: code = ALU_SLT;
          4'b0110: code = ALU_SLTU;
          default: begin
            code    = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      ALUOP_I: begin
        case (funct3)
          3'b000:  code = ALU_ADD;
          3'b100:  code = ALU_XOR;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          3'b001:  code = ALU_SLL;
          3'b101:  code = bit30 ? ALU_SRA : ALU_SRL;
          3'b010:  code = ALU_SLT;
          default: code = ALU_SLTU;
        endcase
      end
      ALUOP_ADD: code = ALU_ADD;
      default: begin
        case (funct3)
          3'b000, 3'b001: code = ALU_XOR;
          3'b100, 3'b101: code = ALU_SLT;
          3'b110, 3'b111: code = ALU_SLTU;
          default: begin
            code    = ALU_XOR;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_share_sched : 2-way round-robin scheduler for one shared ALU           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_share_sched
  import alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int NREQ = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][31:0]     req_instr,
  input  logic [NREQ-1:0][1:0]      req_alu_op,
  input  logic [NREQ-1:0][W-1:0]    req_a,
  input  logic [NREQ-1:0][W-1:0]    req_b,
  output logic [W-1:0]              alu_a,
  output logic [W-1:0]              alu_b,
  output logic [3:0]                alu_ctrl,
  input  logic [W-1:0]              alu_result,
  input  logic                      alu_zero,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [NREQ-1:0][W-1:0]    rsp_result,
  output logic [NREQ-1:0]           rsp_taken,
  output logic [NREQ-1:0]           rsp_illegal
);

  logic [NREQ-1:0][3:0] dec_code;
  logic [NREQ-1:0]      dec_illegal;

  for (genvar g = 0; g < NREQ; g++) begin : g_dec
    alu_op_decode u_dec (
      .instr   (req_instr[g]),
      .alu_op  (req_alu_op[g]),
      .code    (dec_code[g]),
      .illegal (dec_illegal[g])
    );
  end

  logic            rr_ptr_q, rr_ptr_d;
  logic            iss_valid_q, iss_valid_d;
  logic            iss_id_q, iss_id_d;
  logic [3:0]      iss_code_q, iss_code_d;
  logic [W-1:0]    iss_a_q, iss_a_d;
  logic [W-1:0]    iss_b_q, iss_b_d;
  logic [2:0]      iss_f3_q, iss_f3_d;
  logic [1:0]      iss_op_q, iss_op_d;
  logic            iss_illegal_q, iss_illegal_d;

  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0][W-1:0] rsp_result_q, rsp_result_d;
  logic [NREQ-1:0]        rsp_taken_q, rsp_taken_d;
  logic [NREQ-1:0]        rsp_illegal_q, rsp_illegal_d;

  logic [NREQ-1:0] elig;
  logic            grant_vld;
  logic            grant_id;

  // The issue stage always drains into its (guaranteed free) response buffer,
  // so only the per-requester buffer and in-flight state gate eligibility.
  always_comb begin
    elig      = '0;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = ~reset & req_valid[i]
              & (~rsp_valid_q[i] | rsp_ready[i])
              & ~(iss_valid_q & (iss_id_q == 1'(i)));
    end
    grant_vld = |elig;
    grant_id  = (&elig) ? rr_ptr_q : elig[1];
    if (grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    iss_valid_d   = grant_vld;
    iss_id_d      = iss_id_q;
    iss_code_d    = iss_code_q;
    iss_a_d       = iss_a_q;
    iss_b_d       = iss_b_q;
    iss_f3_d      = iss_f3_q;
    iss_op_d      = iss_op_q;
    iss_illegal_d = iss_illegal_q;
    if (grant_vld) begin
      rr_ptr_d      = ~grant_id;
      iss_id_d      = grant_id;
      iss_code_d    = dec_code[grant_id];
      iss_a_d       = req_a[grant_id];
      iss_b_d       = req_b[grant_id];
      iss_f3_d      = req_instr[grant_id][14:12];
      iss_op_d      = req_alu_op[grant_id];
      iss_illegal_d = dec_illegal[grant_id];
    end
  end

  always_comb begin
    rsp_result_d  = rsp_result_q;
    rsp_taken_d   = rsp_taken_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_valid_d   = rsp_valid_q & ~rsp_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (iss_valid_q && (iss_id_q == 1'(i))) begin
        rsp_valid_d[i]   = 1'b1;
        rsp_result_d[i]  = alu_result;
        rsp_taken_d[i]   = (iss_op_q == ALUOP_BR)
                         ? branch_taken(iss_f3_q, alu_zero, alu_result[0]) : 1'b0;
        rsp_illegal_d[i] = iss_illegal_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q      <= 1'b0;
      iss_valid_q   <= 1'b0;
      iss_id_q      <= 1'b0;
      iss_code_q    <= ALU_ADD;
      iss_a_q       <= '0;
      iss_b_q       <= '0;
      iss_f3_q      <= '0;
      iss_op_q      <= ALUOP_R;
      iss_illegal_q <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      rsp_taken_q   <= '0;
      rsp_illegal_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      iss_valid_q   <= iss_valid_d;
      iss_id_q      <= iss_id_d;
      iss_code_q    <= iss_code_d;
      iss_a_q       <= iss_a_d;
      iss_b_q       <= iss_b_d;
      iss_f3_q      <= iss_f3_d;
      iss_op_q      <= iss_op_d;
      iss_illegal_q <= iss_illegal_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_taken_q   <= rsp_taken_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  // Issue regs only load on grant, so the ALU inputs hold while idle.
  assign alu_a       = iss_a_q;
  assign alu_b       = iss_b_q;
  assign alu_ctrl    = iss_code_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_taken   = rsp_taken_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_share_sched : scoreboard bench with behavioural ALU/decode model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_share_sched;

  localparam int W = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid, req_ready;
  logic [1:0][31:0]     req_instr;
  logic [1:0][1:0]      req_alu_op;
  logic [1:0][W-1:0]    req_a, req_b;
  logic [W-1:0]         alu_a, alu_b, alu_result;
  logic [3:0]           alu_ctrl;
  logic                 alu_zero;
  logic [1:0]           rsp_valid, rsp_ready, rsp_taken, rsp_illegal;
  logic [1:0][W-1:0]    rsp_result;

  always #5 clk = ~clk;

  alu_share_sched #(.W(W), .NREQ(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_instr   (req_instr),
    .req_alu_op  (req_alu_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_taken   (rsp_taken),
    .rsp_illegal (rsp_illegal)
  );

  // Shared ALU environment
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[4:0];
      4'b0101: return {31'b0, $signed(a) < $signed(b)};
      4'b0110: return a - b;
      4'b0111: return {31'b0, a < b};
      4'b1000: return a >> b[4:0];
      4'b1001: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'h0);

  typedef enum {O_ADD, O_SUB, O_AND, O_OR, O_XOR, O_SLL, O_SRL, O_SRA, O_SLT, O_SLTU} op_e;

  typedef struct packed {
    logic [31:0] res;
    logic        taken;
    logic        illegal;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } exp_t;

  function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] instr, a, b);
    exp_t e;
    op_e  o;
    logic [2:0] f3;
    logic b30;
    f3 = instr[14:12];
    b30 = instr[30];
    o = O_ADD;
    e = '0;
    e.a = a;
    e.b = b;
    case (op)
      2'b00: case ({f3, b30})
        4'b0000: o = O_ADD;   4'b0001: o = O_SUB;  4'b1000: o = O_XOR;
        4'b1100: o = O_OR;    4'b1110: o = O_AND;  4'b0010: o = O_SLL;
        4'b1010: o = O_SRL;   4'b1011: o = O_SRA;  4'b0100: o = O_SLT;
        4'b0110: o = O_SLTU;
        default: e.illegal = 1'b1;
      endcase
      2'b01: case (f3)
        3'b000: o = O_ADD;  3'b100: o = O_XOR;  3'b110: o = O_OR;  3'b111: o = O_AND;
        3'b001: o = O_SLL;  3'b101: o = b30 ? O_SRA : O_SRL;
        3'b010: o = O_SLT;  default: o = O_SLTU;
      endcase
      2'b10: o = O_ADD;
      default: case (f3)
        3'b000: begin o = O_XOR;  e.taken = (a == b); end
        3'b001: begin o = O_XOR;  e.taken = (a != b); end
        3'b100: begin o = O_SLT;  e.taken = ($signed(a) < $signed(b)); end
        3'b101: begin o = O_SLT;  e.taken = ($signed(a) >= $signed(b)); end
        3'b110: begin o = O_SLTU; e.taken = (a < b); end
        3'b111: begin o = O_SLTU; e.taken = (a >= b); end
        default: begin o = O_XOR; e.illegal = 1'b1; end
      endcase
    endcase
    case (o)
      O_ADD:  begin e.res = a + b;                     e.code = 4'b0010; end
      O_SUB:  begin e.res = a - b;                     e.code = 4'b0110; end
      O_AND:  begin e.res = a & b;                     e.code = 4'b0000; end
      O_OR:   begin e.res = a | b;                     e.code = 4'b0001; end
      O_XOR:  begin e.res = a ^ b;                     e.code = 4'b0011; end
      O_SLL:  begin e.res = a << b[4:0];               e.code = 4'b0100; end
      O_SRL:  begin e.res = a >> b[4:0];               e.code = 4'b1000; end
      O_SRA:  begin e.res = $unsigned($signed(a) >>> b[4:0]); e.code = 4'b1001; end
      O_SLT:  begin e.res = {31'b0, $signed(a) < $signed(b)}; e.code = 4'b0101; end
      default: begin e.res = {31'b0, a < b};           e.code = 4'b0111; end
    endcase
    return e;
  endfunction

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb [2][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, req);
    end
  endtask

  // Monitor: samples mid-cycle, scores responses, arbitration and ALU drive.
  bit   rst_prev = 1'b0;
  bit   ptr      = 1'b0;
  bit   pend_v   = 1'b0;
  exp_t pend;

  always @(negedge clk) begin
    logic [1:0] elig, exp_ready;
    exp_t e;
    cyc++;
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      if (rst_prev) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h2);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_rsp_result0", rsp_result[0], 32'h0);
        chk("rst_rsp_flags", 32'({rsp_taken, rsp_illegal}), 32'h0);
      end
      sb[0].delete();
      sb[1].delete();
      ptr    = 1'b0;
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        chk("alu_ctrl", 32'(alu_ctrl), 32'(pend.code));
        chk("alu_a", alu_a, pend.a);
        chk("alu_b", alu_b, pend.b);
      end
      pend_v = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (sb[i].size() == 0) begin
          chk(i == 0 ? "rsp_valid_idle0" : "rsp_valid_idle1", 32'(rsp_valid[i]), 32'h0);
        end else begin
          e = sb[i][0];
          if (cyc - e.cyc < 2) begin
            chk(i == 0 ? "rsp_early0" : "rsp_early1", 32'(rsp_valid[i]), 32'h0);
          end else begin
            chk(i == 0 ? "rsp_valid0" : "rsp_valid1", 32'(rsp_valid[i]), 32'h1);
            if (rsp_valid[i]) begin
              chk(i == 0 ? "rsp_result0" : "rsp_result1", rsp_result[i], e.res);
              chk(i == 0 ? "rsp_taken0" : "rsp_taken1", 32'(rsp_taken[i]), 32'(e.taken));
              chk(i == 0 ? "rsp_illegal0" : "rsp_illegal1", 32'(rsp_illegal[i]),
                  32'(e.illegal));
              if (rsp_ready[i]) void'(sb[i].pop_front());
            end
          end
        end
      end
      // A requester with any unconsumed request may not issue; ties go to ptr.
      for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (sb[i].size() == 0);
      exp_ready = 2'b00;
      if (elig == 2'b11) exp_ready[ptr] = 1'b1;
      else               exp_ready = elig;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e = ref_model(req_alu_op[i], req_instr[i], req_a[i], req_b[i]);
          e.cyc = cyc;
          sb[i].push_back(e);
          pend   = e;
          pend_v = 1'b1;
          ptr    = (i == 0);
        end
      end
    end
    rst_prev = reset;
  end

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic b30);
    return {1'b0, b30, 15'h0, f3, 12'h0};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      default: return $urandom;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] instr, a, b);
    req_alu_op[i] = op;
    req_instr[i]  = instr;
    req_a[i]      = a;
    req_b[i]      = b;
    req_valid[i]  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b11;
    rsp_ready  = 2'b00;
    req_alu_op = '0;
    req_instr  = '0;
    req_a      = '0;
    req_b      = '0;
    step(3);
    reset     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step(1);

    issue(0, 2'b00, mk(3'b000, 1'b1), 32'd7, 32'd9);
    step(3);

    for (int i = 0; i < 2; i++) begin
      req_alu_op[i] = 2'b10;
      req_instr[i]  = mk(3'b000, 1'b0);
      req_a[i]      = 32'(100 * (i + 1));
      req_b[i]      = 32'(i + 3);
    end
    req_valid = 2'b11;
    step(10);
    req_valid = 2'b00;
    step(3);

    issue(1, 2'b11, mk(3'b000, 1'b0), 32'd5, 32'd5);
    issue(1, 2'b11, mk(3'b001, 1'b0), 32'd5, 32'd5);
    issue(1, 2'b11, mk(3'b100, 1'b0), 32'hFFFF_FFFF, 32'd1);
    issue(1, 2'b11, mk(3'b110, 1'b0), 32'hFFFF_FFFF, 32'd1);
    issue(1, 2'b11, mk(3'b101, 1'b0), 32'd3, 32'd3);
    issue(1, 2'b11, mk(3'b111, 1'b0), 32'd2, 32'd3);
    issue(1, 2'b11, mk(3'b010, 1'b0), 32'd2, 32'd3);
    step(3);

    rsp_ready = 2'b10;
    issue(0, 2'b01, mk(3'b110, 1'b0), 32'hF0, 32'h0F);
    req_valid = 2'b11;
    step(6);
    rsp_ready = 2'b11;
    step(4);
    req_valid = 2'b00;
    step(3);

    issue(0, 2'b00, mk(3'b100, 1'b1), 32'd3, 32'd4);
    step(3);

    req_alu_op[0] = 2'b10;
    req_a[0]      = 32'd1;
    req_b[0]      = 32'd2;
    req_valid[0]  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) break;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    reset     = 1'b1;
    step(1);
    reset = 1'b0;
    step(4);

    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      for (int i = 0; i < 2; i++) begin
        req_instr[i]  = $urandom;
        req_alu_op[i] = 2'($urandom);
        req_a[i]      = pick();
        req_b[i]      = pick();
      end
      step(1);
    end

    reset     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step(8);
    chk("drain_outstanding", 32'(sb[0].size() + sb[1].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
